// File: rtl/seg7_pkg.sv
// seg7_pkg: slot-state enum, hex font table and segment bit indices for the seven-segment scan driver.
package seg7_pkg;
  typedef enum logic {BLANK, ON} slot_state_t;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7: combinational hex nibble to active-high seven-segment font lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_FONT[i_hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner with frame-boundary double buffering.
// Define SEG7_LZ_BLANK_EN to suppress leading-zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp,
  input  logic                  dispValid,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);
  logic [SW-1:0]       r_slot, w_slot_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [4*DIGITS-1:0] r_pending, r_active, w_active_nxt;
  slot_state_t         r_state, w_state_nxt;
  logic                w_slot_end, w_wrap;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_show, w_dig;
  assign w_slot_end = r_slot == SW'(SCAN_DIV - 1);
  assign w_wrap     = w_slot_end && r_idx == IW'(DIGITS - 1);
  // Outputs are registered from next-state values so pins line up with the counters.
  always_comb begin
    w_slot_nxt   = w_slot_end ? '0 : r_slot + SW'(1);
    w_idx_nxt    = w_wrap ? '0 : w_slot_end ? r_idx + IW'(1) : r_idx;
    w_active_nxt = w_wrap ? (dispValid ? disp : r_pending) : r_active;
    w_state_nxt  = w_slot_end ? ((BLANK_CYCLES == 0) ? ON : BLANK)
                 : (r_state == BLANK && w_slot_nxt >= SW'(BLANK_CYCLES)) ? ON : r_state;
    w_nib        = 4'(w_active_nxt >> (4 * w_idx_nxt));
    w_dig        = (w_state_nxt == ON) ? ((DIGITS'(1) << w_idx_nxt) & w_show) : '0;
  end
`ifdef SEG7_LZ_BLANK_EN
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_d0
      assign w_show[i] = 1'b1;
    end else begin : g_dn
      assign w_show[i] = |w_active_nxt[4*DIGITS-1:4*i];
    end
  end
`else
  assign w_show = '1;
`endif
  hex_to_seg7 u_font (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BLANK;
      r_slot     <= '0;
      r_idx      <= '0;
      r_pending  <= '0;
      r_active   <= '0;
      seg        <= {7{INV}};
      dig_en     <= {DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_idx      <= w_idx_nxt;
      r_active   <= w_active_nxt;
      if (dispValid) r_pending <= disp;
      seg        <= w_seg ^ {7{INV}};
      dig_en     <= w_dig ^ {DIGITS{INV}};
      frame_done <= w_slot_nxt == SW'(SCAN_DIV - 1) && w_idx_nxt == IW'(DIGITS - 1);
    end
  end
endmodule
